// File: rtl/id_pkg.sv
// Decoder-side definitions shared with the fetch stage: opcode encodings of the
// accumulator CPU. Only NOP is referenced by fetch; the rest document the map.
package id_pkg;

  typedef enum logic [3:0] {
    NOP  = 4'h0,
    LDA  = 4'h1,
    STA  = 4'h2,
    ADD  = 4'h3,
    SUB  = 4'h4,
    JMP  = 4'h5,
    JZ   = 4'h6,
    HALT = 4'hF
  } opcode_t;

endpackage

// File: rtl/if_pkg.sv
// Fetch-stage package: FSM state type, opcode field geometry shared with the
// decoder, and the NOP word presented when no instruction is held.
package if_pkg;

  localparam int INSTR_W_DEF = 16;
  localparam int OPCODE_W    = 4;
  localparam int OPCODE_MSB  = INSTR_W_DEF - 1;

  typedef enum logic [1:0] {
    FETCH_REQ = 2'd0,
    WAIT_RSP  = 2'd1,
    ISSUE     = 2'd2,
    DRAIN     = 2'd3
  } fetch_state_t;

  localparam logic [INSTR_W_DEF-1:0] NOP_WORD = {id_pkg::NOP, 12'h000};

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read bus: req/addr from fetch, valid/rdata back from memory.
interface instruction_fetch_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface

// File: rtl/program_counter.sv
// Program counter: load (redirect) has priority over increment; wraps naturally
// modulo 2**ADDR_W.
module program_counter #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_reg;

  // PC register: redirect beats sequential advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (load) begin
      pc_reg <= load_value;
    end else if (inc) begin
      pc_reg <= pc_reg + ADDR_W'(1);
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, runs the imem req/valid handshake and holds the
// fetched word in a registered instruction register feeding the decoder.
module instruction_fetch
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master imem,
  input  logic                stall,
  input  logic                jump_en,
  input  logic [ADDR_W-1:0]   jump_addr,
  output logic [INSTR_W-1:0]  instruction,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   pc_out
);

  // NOP sized to this instance's instruction width
  localparam logic [INSTR_W-1:0] NOP_INSTR = {id_pkg::NOP, {(INSTR_W-OPCODE_W){1'b0}}};

  fetch_state_t       state_reg, state_next;
  logic [INSTR_W-1:0] ir_reg, ir_next;
  logic [ADDR_W-1:0]  pc_out_reg, pc_out_next;
  logic               valid_reg, valid_next;
  logic               pc_load, pc_inc;
  logic [ADDR_W-1:0]  pc;

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .load_value (jump_addr),
    .inc        (pc_inc),
    .pc         (pc)
  );

  // State, instruction register and presented-PC registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= FETCH_REQ;
      ir_reg     <= NOP_INSTR;
      pc_out_reg <= RESET_PC;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ir_reg     <= ir_next;
      pc_out_reg <= pc_out_next;
      valid_reg  <= valid_next;
    end
  end

  // Next-state and datapath control; a jump overrides everything else
  always_comb begin
    state_next  = state_reg;
    ir_next     = ir_reg;
    pc_out_next = pc_out_reg;
    valid_next  = valid_reg;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;

    if (jump_en) begin
      pc_load    = 1'b1;
      valid_next = 1'b0;
      ir_next    = NOP_INSTR;
      case (state_reg)
        // A response is still owed unless it lands this very cycle
        WAIT_RSP, DRAIN: state_next = imem.imem_valid ? FETCH_REQ : DRAIN;
        default:         state_next = FETCH_REQ;
      endcase
    end else begin
      case (state_reg)
        FETCH_REQ: begin
          state_next = WAIT_RSP;
        end
        WAIT_RSP: begin
          if (imem.imem_valid) begin
            ir_next     = imem.imem_rdata;
            pc_out_next = pc;
            pc_inc      = 1'b1;
            valid_next  = 1'b1;
            state_next  = ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            valid_next = 1'b0;
            ir_next    = NOP_INSTR;
            state_next = FETCH_REQ;
          end
        end
        DRAIN: begin
          if (imem.imem_valid) begin
            state_next = FETCH_REQ;
          end
        end
        default: state_next = FETCH_REQ;
      endcase
    end
  end

  // Request is driven from state; gated by rst so it drops as soon as reset asserts
  assign imem.imem_req  = !rst && ((state_reg == FETCH_REQ) || (state_reg == WAIT_RSP));
  assign imem.imem_addr = pc;

  assign instruction = ir_reg;
  assign instr_valid = valid_reg;
  assign pc_out      = pc_out_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-programmable imem model.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc_out;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [256];
  int          lat;
  logic        busy;
  int          cnt;
  logic [7:0]  addr_l;

  instruction_fetch_if #(.ADDR_W(8), .INSTR_W(16)) imem_bus ();

  instruction_fetch #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc_out      (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: response strobe 'lat' cycles after the request is first seen
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy                <= 1'b0;
      cnt                 <= 0;
      addr_l              <= 8'h00;
      imem_bus.imem_valid <= 1'b0;
      imem_bus.imem_rdata <= 16'h0000;
    end else begin
      imem_bus.imem_valid <= 1'b0;
      if (busy) begin
        if (cnt <= 1) begin
          imem_bus.imem_valid <= 1'b1;
          imem_bus.imem_rdata <= mem[addr_l];
          busy                <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end else if (imem_bus.imem_req && !imem_bus.imem_valid) begin
        if (lat <= 1) begin
          imem_bus.imem_valid <= 1'b1;
          imem_bus.imem_rdata <= mem[imem_bus.imem_addr];
        end else begin
          busy   <= 1'b1;
          cnt    <= lat - 1;
          addr_l <= imem_bus.imem_addr;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wait for instr_valid at a falling edge; returns cycles waited
  task automatic wait_valid(input int max, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!instr_valid && cycles < max);
    if (!instr_valid) chk("valid_timeout", 32'(instr_valid), 32'd1);
    else $display("issue pc=%02h instr=%04h after %0d cycles", pc_out, instruction, cycles);
  endtask

  // Wait for imem_req; also reports whether instr_valid rose meanwhile
  task automatic wait_req(input int max, output logic saw_valid);
    int n;
    n = 0;
    saw_valid = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (instr_valid) saw_valid = 1'b1;
    end while (!imem_bus.imem_req && n < max);
    if (!imem_bus.imem_req) chk("req_timeout", 32'(imem_bus.imem_req), 32'd1);
    else $display("req addr=%02h", imem_bus.imem_addr);
  endtask

  initial begin
    int   cyc;
    logic sv;
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000 | 16'(i);
    mem[8'h00] = 16'h1401;
    mem[8'h01] = 16'h2002;
    mem[8'h02] = 16'h3003;
    mem[8'h03] = 16'h6003;
    mem[8'h20] = 16'h8020;
    mem[8'h40] = 16'h5040;
    mem[8'hFF] = 16'h7FFF;
    lat       = 1;
    stall     = 1'b0;
    jump_en   = 1'b0;
    jump_addr = 8'h00;
    rst       = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_instr", 32'(instruction), 32'(if_pkg::NOP_WORD));
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req",   32'(imem_bus.imem_req), 32'd0);
    chk("rst_pcout", 32'(pc_out), 32'h00);
    rst = 1'b0;
    #1;
    chk("first_req",  32'(imem_bus.imem_req), 32'd1);
    chk("first_addr", 32'(imem_bus.imem_addr), 32'h00);

    // 1: sequential fetch at latency 1
    wait_valid(10, cyc);
    chk("t1_i0", 32'(instruction), 32'h1401);
    chk("t1_p0", 32'(pc_out), 32'h00);
    wait_valid(10, cyc);
    chk("t1_i1",   32'(instruction), 32'h2002);
    chk("t1_p1",   32'(pc_out), 32'h01);
    chk("t1_rate", 32'(cyc), 32'd3);

    // 2: stall holds the instruction in ISSUE
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_hold_i", 32'(instruction), 32'h2002);
      chk("t2_hold_v", 32'(instr_valid), 32'd1);
      chk("t2_hold_r", 32'(imem_bus.imem_req), 32'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("t2_rel_v",    32'(instr_valid), 32'd0);
    chk("t2_rel_r",    32'(imem_bus.imem_req), 32'd1);
    chk("t2_rel_addr", 32'(imem_bus.imem_addr), 32'h02);
    wait_valid(10, cyc);
    chk("t2_i2", 32'(instruction), 32'h3003);
    chk("t2_p2", 32'(pc_out), 32'h02);

    // 3: jump in first WAIT_RSP cycle at latency 3 -> DRAIN
    lat = 3;
    wait_req(10, sv);
    chk("t3_addr3", 32'(imem_bus.imem_addr), 32'h03);
    @(negedge clk);
    chk("t3_wait_req", 32'(imem_bus.imem_req), 32'd1);
    jump_en   = 1'b1;
    jump_addr = 8'h40;
    @(negedge clk);
    jump_en = 1'b0;
    chk("t3_drain_req", 32'(imem_bus.imem_req), 32'd0);
    chk("t3_drain_v",   32'(instr_valid), 32'd0);
    wait_req(10, sv);
    chk("t3_no_issue", 32'(sv), 32'd0);
    chk("t3_new_addr", 32'(imem_bus.imem_addr), 32'h40);
    lat = 1;
    wait_valid(10, cyc);
    chk("t3_i", 32'(instruction), 32'h5040);
    chk("t3_p", 32'(pc_out), 32'h40);

    // 4: jump with stall in ISSUE drops the held word; then PC wrap at 8'hFF
    stall     = 1'b1;
    jump_en   = 1'b1;
    jump_addr = 8'hFF;
    @(negedge clk);
    stall   = 1'b0;
    jump_en = 1'b0;
    chk("t4_drop_v", 32'(instr_valid), 32'd0);
    chk("t4_drop_i", 32'(instruction), 32'(if_pkg::NOP_WORD));
    chk("t4_addr",   32'(imem_bus.imem_addr), 32'hFF);
    wait_valid(10, cyc);
    chk("t4_iff", 32'(instruction), 32'h7FFF);
    chk("t4_pff", 32'(pc_out), 32'hFF);
    wait_req(10, sv);
    chk("t4_wrap", 32'(imem_bus.imem_addr), 32'h00);
    wait_valid(10, cyc);
    chk("t4_i0", 32'(instruction), 32'h1401);
    wait_valid(10, cyc);
    chk("t4_p1", 32'(pc_out), 32'h01);

    // 5: reset asserted in WAIT_RSP
    lat = 3;
    wait_req(10, sv);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_instr", 32'(instruction), 32'(if_pkg::NOP_WORD));
    chk("t5_req",   32'(imem_bus.imem_req), 32'd0);
    chk("t5_pcout", 32'(pc_out), 32'h00);
    chk("t5_valid", 32'(instr_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_req_rel", 32'(imem_bus.imem_req), 32'd1);
    chk("t5_addr",    32'(imem_bus.imem_addr), 32'h00);
    wait_valid(12, cyc);
    chk("t5_i0", 32'(instruction), 32'h1401);

    // 6: jump and imem_valid in the same WAIT_RSP cycle
    lat = 1;
    wait_req(10, sv);
    @(negedge clk);
    jump_en   = 1'b1;
    jump_addr = 8'h20;
    @(negedge clk);
    jump_en = 1'b0;
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_req",   32'(imem_bus.imem_req), 32'd1);
    chk("t6_addr",  32'(imem_bus.imem_addr), 32'h20);
    wait_valid(10, cyc);
    chk("t6_i", 32'(instruction), 32'h8020);
    chk("t6_p", 32'(pc_out), 32'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
